decoder_scan: RTL
=================

# decoder_scan

Registered 3-to-8 one-hot decoder, the counterpart to the team's 8-to-3 `encoder`. It turns a 3-bit binary code into a one-hot `octal_out` word through a valid/ready handshake. It also has a self-timed scan mode that walks the one-hot bit from 0x01 to 0x80, for lamp, LED and select-line test sequencing. It sits between control logic that produces codes and the one-hot select lines it drives.

## Interface
- SCAN_DIV, 1: clock cycles each code is held in scan mode; legal range 1..65535; 16-bit internal divider.
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- sel  input  1  mode: 0 = direct decode, 1 = scan; only meaningful in IDLE.
- binary_in  input  3  code to decode (direct mode).
- in_valid  input  1  binary_in is valid.
- in_ready  output  1  decoder accepts a code this cycle; combinational, equals (state == IDLE) && !sel.
- start  input  1  begin a scan; only honoured in IDLE with sel=1.
- octal_out  output  8  registered one-hot result; 0x00 when nothing is driven.
- out_valid  output  1  one-cycle pulse whenever octal_out takes a new non-zero code.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a scan completes.

## Operation
- States:
  - IDLE: decode or wait.
  - SCAN: walking one-hot.
- Reset: when rst_n is low at a clock edge, the state goes to IDLE and these registers clear: octal_out=0x00, out_valid=0, done=0, busy=0, the divider and the scan index.
  - Reset takes priority over every other input, including mid-scan; a scan is abandoned with no done pulse.
- Direct decode (IDLE, sel=0):
  - A code is accepted on an edge where in_valid && in_ready.
  - octal_out <= 1 << binary_in; out_valid pulses.
  - octal_out holds until the next accept or a scan.
  - A repeated identical code still pulses out_valid.
  - start is ignored.
- Scan start (IDLE, sel=1, start=1):
  - Go to SCAN, set the index to 0, set octal_out=0x01, pulse out_valid, set busy=1.
  - in_valid is ignored, and in_ready is 0.
- SCAN:
  - The divider counts SCAN_DIV cycles for each code.
  - On expiry with index < 7: index++, octal_out shifts left by 1, out_valid pulses.
  - On expiry with index == 7: octal_out=0x00, busy=0, done pulses, return to IDLE.
  - sel, start, in_valid and binary_in are all ignored in SCAN; sel is sampled only at start.
- octal_out is always 0x00 or exactly one bit set; never multi-hot.
- Back-to-back operation:
  - The cycle after done, IDLE accepts a new start or code.
  - start held high re-triggers a new scan the cycle after done.
- No X propagation: binary_in is used only when accepted.

## Timing
- Direct mode:
  - Accept at edge N; octal_out and out_valid valid after edge N.
  - Latency 1 cycle; throughput 1 code per cycle with in_valid held high.
- Scan mode, start sampled at edge N:
  - Code 2^k is present from edge N+k·SCAN_DIV to edge N+(k+1)·SCAN_DIV, for k=0..7.
  - out_valid is high in the first cycle of each code.
  - At edge N+8·SCAN_DIV: octal_out=0x00, done=1 for that cycle, busy=0, in_ready follows sel.
- With SCAN_DIV=1, the output changes every cycle and out_valid is high for 8 consecutive cycles.
- in_ready changes combinationally with sel while in IDLE; it is 0 in SCAN. During reset, state is IDLE after the first reset edge.

## Test plan
- Reset: rst_n=0 for 2 cycles, with in_valid=1, sel=0 and binary_in=3'd5 driven at the same time.
  - Required after the reset edge: octal_out=0x00, out_valid=0, busy=0, done=0.
  - The first accept after release gives 0x20.
- Direct sweep: sel=0, in_valid=1, binary_in=0..7 on consecutive cycles.
  - Required: octal_out 0x01, 0x02, 0x04, 0x08, 0x10, 0x20, 0x40, 0x80, one cycle after each code, with out_valid high throughout.
  - Dropping in_valid afterwards holds octal_out at 0x80.
- Scan with SCAN_DIV=3, start pulsed at edge N.
  - Required: 0x01 from N to N+3, 0x02 from N+3, and so on, with 0x80 ending at N+24.
  - Required: 8 out_valid pulses, busy high for 24 cycles, done high exactly once at N+24, octal_out=0x00.
- Ignored inputs mid-scan:
  - Toggle sel, pulse start, and drive in_valid=1 with binary_in=3'd2 during SCAN.
  - Required: sequence and done timing unchanged, in_ready=0 throughout.
- Reset mid-scan:
  - rst_n=0 at the 4th code (0x08).
  - Required: next cycle octal_out=0x00, busy=0, and no done pulse.
- Priority and exclusivity:
  - In IDLE with sel=0, assert start and in_valid with binary_in=3'd7 together. Required: decode to 0x80, no scan.
  - Check every cycle of all tests: octal_out is 0x00 or one-hot.

Source files
------------

// File: rtl/decoder_scan.sv
// Registered 3-to-8 one-hot decoder with a valid/ready direct path and a
// self-timed scan mode that walks the one-hot bit from 0x01 to 0x80.
module decoder_scan #(
  parameter int unsigned SCAN_DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sel,
  input  logic [2:0] binary_in,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       start,
  output logic [7:0] octal_out,
  output logic       out_valid,
  output logic       busy,
  output logic       done
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  octal_q, octal_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] div_q, div_d;
  logic [2:0]  idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      octal_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      octal_q     <= octal_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_q       <= div_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    octal_d     = octal_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    div_d       = div_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (sel) begin
          if (start) begin
            state_d     = SCAN;
            idx_d       = '0;
            div_d       = '0;
            octal_d     = 8'h01;
            out_valid_d = 1'b1;
            busy_d      = 1'b1;
          end
        end else if (in_valid) begin
          octal_d     = 8'h01 << binary_in;
          out_valid_d = 1'b1;
        end
      end
      SCAN: begin
        // Each code is held for SCAN_DIV cycles; the last expiry ends the scan.
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (idx_q == 3'd7) begin
            state_d = IDLE;
            octal_d = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d       = idx_q + 3'd1;
            octal_d     = {octal_q[6:0], 1'b0};
            out_valid_d = 1'b1;
          end
        end else begin
          div_d = div_q + 16'd1;
        end
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE) && !sel;
  assign octal_out = octal_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
